// File: rtl/open1553_pkg.sv
// Shared MIL-STD-1553 definitions for the encoder, the decoder and util_dac_diff.
//  - diff level codes driven on the differential DAC path
//  - command/status and data sync patterns (1 = positive half-bit, MSB first)
//  - half-bit rate and word length in half-bits
//  - helpers: odd parity, polarity-to-code mapping, 40-half-bit word pattern builder
package open1553_pkg;

    localparam logic [1:0] DIFF_POS  = 2'b10;
    localparam logic [1:0] DIFF_NEG  = 2'b01;
    localparam logic [1:0] DIFF_IDLE = 2'b00;

    localparam int HALF_BIT_RATE  = 2000000;
    localparam int WORD_HALF_BITS = 40;
    localparam int SYNC_HALF_BITS = 6;
    localparam int DATA_HALF_BITS = 32;

    // Polarity sequences, first half-bit in the MSB.
    localparam logic [5:0] SYNC_CMD  = 6'b111000;
    localparam logic [5:0] SYNC_DATA = 6'b000111;

    // Odd parity over the 16 data bits: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [15:0] data);
        return ~^data;
    endfunction

    // Map a half-bit polarity (1 = positive) onto the differential level code.
    function automatic logic [1:0] level_code(input logic pol);
        logic [1:0] code;
        if (pol) begin
            code = DIFF_POS;
        end else begin
            code = DIFF_NEG;
        end
        return code;
    endfunction

    // Full word as 40 polarity half-bits, first half-bit in bit 39.
    // A logic 1 is sent positive-then-negative, a logic 0 negative-then-positive.
    function automatic logic [39:0] build_pattern(input logic [15:0] data, input logic cmd);
        logic [39:0] pat;
        pat = 40'd0;
        if (cmd) begin
            pat[39:34] = SYNC_CMD;
        end else begin
            pat[39:34] = SYNC_DATA;
        end
        for (int i = 0; i < 16; i++) begin
            if (data[15-i]) begin
                pat[33-2*i -: 2] = 2'b10;
            end else begin
                pat[33-2*i -: 2] = 2'b01;
            end
        end
        if (odd_parity(data)) begin
            pat[1:0] = 2'b10;
        end else begin
            pat[1:0] = 2'b01;
        end
        return pat;
    endfunction

endpackage

// File: rtl/util_halfbit_strobe.sv
// Half-bit timing counter.
//  clk, rstn   : clock, asynchronous active-low reset
//  enable      : count while a word is being sent; held at zero otherwise
//  restart     : force the count back to zero (word accepted)
//  strobe      : high on the last clock of each HALF_BIT_CYCLES-long half-bit
//  pre_strobe  : high on the clock before strobe will fire (always high when a
//                half-bit lasts a single clock)
module util_halfbit_strobe #(
    parameter int HALF_BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic restart,
    output logic strobe,
    output logic pre_strobe
);

    localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = (HALF_BIT_CYCLES > 1) ? CW'(HALF_BIT_CYCLES - 2) : {CW{1'b0}};
    localparam bit SINGLE_CYCLE = (HALF_BIT_CYCLES == 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;

    // Next count: restart wins, wrap at the end of a half-bit, park at zero when idle.
    always_comb begin
        cnt_next_s = cnt_r;
        if (restart) begin
            cnt_next_s = {CW{1'b0}};
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_next_s = {CW{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_next_s = {CW{1'b0}};
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign strobe     = enable && (cnt_r == CNT_LAST);
    assign pre_strobe = enable && (SINGLE_CYCLE || (cnt_r == CNT_PRE));

endmodule

// File: rtl/axis_1553_diff_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II differential encoder.
//  clk, rstn      : clock, asynchronous active-low reset
//  s_axis_tdata   : 16-bit word, sent MSB first
//  s_axis_tuser   : 1 = command/status sync, 0 = data sync
//  s_axis_tvalid  : word valid
//  s_axis_tready  : word can be accepted (idle, or last clock of a word)
//  diff_out       : 10 positive, 01 negative, 00 idle
//  tx_active      : high while a half-bit of a word is on diff_out
// The internal state runs one clock ahead of the registered outputs, which gives
// the one-clock latency from handshake to the first sync half-bit.
module axis_1553_diff_encoder
    import open1553_pkg::*;
#(
    parameter int CLOCK_SPEED = 2000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  diff_out,
    output logic        tx_active
);

    localparam int HALF_BIT_CYCLES = CLOCK_SPEED / HALF_BIT_RATE;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_PARITY = 2'd3;

    localparam logic [5:0] IDX_LAST       = 6'(WORD_HALF_BITS - 1);
    localparam logic [5:0] IDX_PRE_LAST   = 6'(WORD_HALF_BITS - 2);
    localparam logic [5:0] IDX_DATA_FIRST = 6'(SYNC_HALF_BITS);
    localparam logic [5:0] IDX_PAR_FIRST  = 6'(SYNC_HALF_BITS + DATA_HALF_BITS);

    logic [1:0]  state_r, state_next_s;
    logic [5:0]  idx_r, idx_next_s, idx_inc_s;
    logic [39:0] pat_r, pat_next_s;
    logic [1:0]  diff_out_r;
    logic        tx_active_r;
    logic        tready_r, tready_next_s;
    logic        handshake_s;
    logic        active_s;
    logic        strobe_s;
    logic        pre_strobe_s;
    logic        final_next_s;

    assign handshake_s = s_axis_tvalid && tready_r;
    assign active_s    = (state_r != ST_IDLE);
    assign idx_inc_s   = idx_r + 6'd1;

    util_halfbit_strobe #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_strobe (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (active_s),
        .restart    (handshake_s),
        .strobe     (strobe_s),
        .pre_strobe (pre_strobe_s)
    );

    // Word sequencing: load on handshake, step one half-bit per strobe, chain or stop after parity.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        pat_next_s   = pat_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_next_s = ST_SYNC;
                    idx_next_s   = 6'd0;
                    pat_next_s   = build_pattern(s_axis_tdata, s_axis_tuser);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SYNC, ST_DATA, ST_PARITY: begin
                if (strobe_s) begin
                    if (idx_r == IDX_LAST) begin
                        if (handshake_s) begin
                            state_next_s = ST_SYNC;
                            idx_next_s   = 6'd0;
                            pat_next_s   = build_pattern(s_axis_tdata, s_axis_tuser);
                        end else begin
                            state_next_s = ST_IDLE;
                            idx_next_s   = 6'd0;
                            pat_next_s   = 40'd0;
                        end
                    end else begin
                        idx_next_s = idx_inc_s;
                        pat_next_s = {pat_r[38:0], 1'b0};
                        if (idx_inc_s < IDX_DATA_FIRST) begin
                            state_next_s = ST_SYNC;
                        end else if (idx_inc_s < IDX_PAR_FIRST) begin
                            state_next_s = ST_DATA;
                        end else begin
                            state_next_s = ST_PARITY;
                        end
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = 6'd0;
                pat_next_s   = 40'd0;
            end
        endcase
    end

    // Ready for the next clock: idle, or the next clock is the last one of the final half-bit.
    // With single-clock half-bits that happens one strobe before the last index.
    always_comb begin
        final_next_s = 1'b0;
        if (!handshake_s && active_s && pre_strobe_s) begin
            final_next_s = (strobe_s && (idx_r == IDX_PRE_LAST)) ||
                           (!strobe_s && (idx_r == IDX_LAST));
        end else begin
            final_next_s = 1'b0;
        end
        tready_next_s = (state_next_s == ST_IDLE) || final_next_s;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            idx_r   <= 6'd0;
            pat_r   <= 40'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            pat_r   <= pat_next_s;
        end
    end

    // Registered outputs, one clock behind the sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            diff_out_r  <= DIFF_IDLE;
            tx_active_r <= 1'b0;
            tready_r    <= 1'b0;
        end else begin
            if (active_s) begin
                diff_out_r <= level_code(pat_r[39]);
            end else begin
                diff_out_r <= DIFF_IDLE;
            end
            tx_active_r <= active_s;
            tready_r    <= tready_next_s;
        end
    end

    assign s_axis_tready = tready_r;
    assign diff_out      = diff_out_r;
    assign tx_active     = tx_active_r;

endmodule
